residue_mac_mod_113: RTL and testbench

Sequential modulo-113 multiply-accumulate stage that sits directly downstream of the 100-bit → mod-113 input reducer. It consumes a stream of 7-bit residue pairs (a, b) over a valid/ready handshake. It accumulates Σ a·b mod 113 over a fixed number of terms and presents one 7-bit result per block on a second valid/ready handshake. It is the per-channel dot-product engine of the mod-113 RNS lane.

---
 rtl/residue_mac_mod_113.sv | 129 ++++++++++++
 tb/tb_residue_mac_mod_113.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/residue_mac_mod_113.sv
// Modulo-113 multiply-accumulate stage: accepts NTerms residue pairs, emits sum(a*b) mod 113.
// Two-stage datapath: stage 1 registers the raw product, stage 2 reduces it and folds it
// into the accumulator. A three-state FSM sequences accumulate / drain / result-hold.
module residue_mac_mod_113 #(
  parameter int unsigned NTerms = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [6:0] in_a_i,
  input  logic [6:0] in_b_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [6:0] out_r_o,
  output logic       out_err_o
);

  typedef enum logic [1:0] {StAcc, StDrain, StDone} state_e;

  state_e      state_q;
  logic [6:0]  acc_q;
  logic [7:0]  cnt_q;
  logic        err_q;
  logic        out_valid_q;
  logic        s1_valid_q;
  logic        s1_last_q;
  logic        s1_err_q;
  logic [13:0] s1_p_q;

  logic        accept;
  logic        last_term;
  logic        op_err;
  logic [6:0]  a_n;
  logic [6:0]  b_n;
  logic [13:0] prod;
  logic [10:0] fold1;
  logic [8:0]  fold2;
  logic [7:0]  fold3;
  logic [7:0]  fold3_sub;
  logic [6:0]  pm;
  logic [7:0]  sum;
  logic [7:0]  sum_sub;
  logic [6:0]  acc_nxt;

  assign in_ready_o  = (state_q == StAcc);
  assign out_valid_o = out_valid_q;
  assign out_r_o     = out_valid_q ? acc_q : 7'd0;
  assign out_err_o   = out_valid_q & err_q;

  // Operand normalisation, product and modular reduction of the stage-1 product.
  always_comb begin
    accept    = in_valid_i && in_ready_o && !clr_i;
    last_term = ((cnt_q + 8'd1) == NTerms[7:0]);
    op_err    = (in_a_i >= 7'd113) || (in_b_i >= 7'd113);
    a_n       = (in_a_i >= 7'd113) ? in_a_i - 7'd113 : in_a_i;
    b_n       = (in_b_i >= 7'd113) ? in_b_i - 7'd113 : in_b_i;
    prod      = 14'(a_n) * 14'(b_n);
    // 2^7 = 15 (mod 113); three folds bring any 14-bit product below 158.
    fold1     = 11'(s1_p_q[13:7]) * 11'd15 + 11'(s1_p_q[6:0]);
    fold2     = 9'(fold1[10:7]) * 9'd15 + 9'(fold1[6:0]);
    fold3     = 8'(fold2[8:7]) * 8'd15 + 8'(fold2[6:0]);
    fold3_sub = fold3 - 8'd113;
    pm        = (fold3 >= 8'd113) ? fold3_sub[6:0] : fold3[6:0];
    sum       = {1'b0, acc_q} + {1'b0, pm};
    sum_sub   = sum - 8'd113;
    acc_nxt   = (sum >= 8'd113) ? sum_sub[6:0] : sum[6:0];
  end

  // FSM, pipeline registers and accumulator; clr outranks everything except reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StAcc;
      acc_q       <= 7'd0;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_p_q      <= 14'd0;
    end else if (clr_i) begin
      state_q     <= StAcc;
      acc_q       <= 7'd0;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_err_q    <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_p_q    <= prod;
        s1_last_q <= last_term;
        s1_err_q  <= op_err;
        cnt_q     <= cnt_q + 8'd1;
      end
      if (s1_valid_q) begin
        acc_q <= acc_nxt;
        err_q <= err_q | s1_err_q;
      end
      unique case (state_q)
        StAcc: begin
          if (accept && last_term) state_q <= StDrain;
        end
        StDrain: begin
          if (s1_valid_q && s1_last_q) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          // Stage 1 is empty here, so these clears never race an accumulate.
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            acc_q       <= 7'd0;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
            state_q     <= StAcc;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

endmodule

// File: tb/tb_residue_mac_mod_113.sv
// Self-checking bench for residue_mac_mod_113: directed scenarios plus randomized blocks
// compared against a plain-arithmetic dot-product model.
module tb_residue_mac_mod_113;

  localparam int unsigned NTerms = 4;

  logic       clk_i;
  logic       rst_ni;
  logic       clr_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [6:0] in_a_i;
  logic [6:0] in_b_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [6:0] out_r_o;
  logic       out_err_o;

  int n_checks;
  int n_fail;
  int ta[NTerms];
  int tb[NTerms];

  residue_mac_mod_113 #(
    .NTerms(NTerms)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clr_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_a_i     (in_a_i),
    .in_b_i     (in_b_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_r_o    (out_r_o),
    .out_err_o  (out_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: normalise each operand to its residue, plain sum of products, one final mod.
  function automatic int ref_r();
    int s = 0;
    for (int i = 0; i < NTerms; i++) s += (ta[i] % 113) * (tb[i] % 113);
    return s % 113;
  endfunction

  function automatic int ref_err();
    int e = 0;
    for (int i = 0; i < NTerms; i++) if (ta[i] >= 113 || tb[i] >= 113) e = 1;
    return e;
  endfunction

  task automatic send_term(input int a, input int b, input int gaps);
    int w;
    in_valid_i = 1'b0;
    repeat (gaps) step();
    in_a_i     = a[6:0];
    in_b_i     = b[6:0];
    in_valid_i = 1'b1;
    w = 0;
    while (!in_ready_o && w < 20) begin
      step();
      w++;
    end
    check_eq("accept_ready", int'(in_ready_o), 1);
    step();
    in_valid_i = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 valid pattern 1,0,0,1,..., 2 random gaps.
  task automatic run_block(input string tag, input int gap_mode, input int hold);
    int gaps;
    int r_hold;
    for (int i = 0; i < NTerms; i++) begin
      gaps = (gap_mode == 1) ? ((i == 0) ? 0 : 2) :
             (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      send_term(ta[i], tb[i], gaps);
    end
    check_eq({tag, "_valid_k"}, int'(out_valid_o), 0);
    check_eq({tag, "_ready_k"}, int'(in_ready_o), 0);
    step();
    check_eq({tag, "_valid_k1"}, int'(out_valid_o), 1);
    check_eq({tag, "_r"}, int'(out_r_o), ref_r());
    check_eq({tag, "_err"}, int'(out_err_o), ref_err());
    r_hold = ref_r();
    for (int c = 0; c < hold; c++) begin
      step();
      check_eq({tag, "_hold_valid"}, int'(out_valid_o), 1);
      check_eq({tag, "_hold_r"}, int'(out_r_o), r_hold);
      check_eq({tag, "_hold_ready"}, int'(in_ready_o), 0);
    end
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check_eq({tag, "_hs_valid"}, int'(out_valid_o), 0);
    check_eq({tag, "_hs_r"}, int'(out_r_o), 0);
    check_eq({tag, "_hs_err"}, int'(out_err_o), 0);
    check_eq({tag, "_hs_ready"}, int'(in_ready_o), 1);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_ni      = 1'b0;
    clr_i       = 1'b0;
    in_valid_i  = 1'b0;
    in_a_i      = 7'd0;
    in_b_i      = 7'd0;
    out_ready_i = 1'b0;
    #12;
    check_eq("rst_valid", int'(out_valid_o), 0);
    check_eq("rst_r", int'(out_r_o), 0);
    check_eq("rst_err", int'(out_err_o), 0);
    check_eq("rst_ready", int'(in_ready_o), 1);
    rst_ni = 1'b1;
    step();

    ta = '{1, 2, 112, 100};
    tb = '{1, 3, 112, 50};
    run_block("basic", 0, 0);
    check_eq("basic_model", ref_r(), 36);

    ta = '{112, 112, 112, 112};
    tb = '{1, 1, 1, 1};
    run_block("wrap", 0, 0);

    ta = '{127, 0, 0, 0};
    tb = '{1, 0, 0, 0};
    run_block("operr", 0, 0);
    ta = '{0, 0, 0, 0};
    tb = '{0, 0, 0, 0};
    run_block("zeros", 0, 0);

    ta = '{1, 2, 112, 100};
    tb = '{1, 3, 112, 50};
    run_block("bp", 0, 10);
    run_block("toggle", 1, 0);

    // Abort after two terms; the term offered alongside clr must be dropped.
    send_term(9, 9, 0);
    send_term(7, 3, 0);
    in_a_i     = 7'd50;
    in_b_i     = 7'd60;
    in_valid_i = 1'b1;
    clr_i      = 1'b1;
    step();
    clr_i      = 1'b0;
    in_valid_i = 1'b0;
    check_eq("clr_ready", int'(in_ready_o), 1);
    check_eq("clr_valid", int'(out_valid_o), 0);
    step();
    ta = '{5, 5, 5, 5};
    tb = '{5, 5, 5, 5};
    run_block("after_clr", 0, 0);

    // Asynchronous reset while a result is being held.
    for (int i = 0; i < NTerms; i++) send_term(30 + i, 40, 0);
    step();
    check_eq("pre_rst_valid", int'(out_valid_o), 1);
    rst_ni = 1'b0;
    #1;
    check_eq("arst_valid", int'(out_valid_o), 0);
    check_eq("arst_r", int'(out_r_o), 0);
    check_eq("arst_ready", int'(in_ready_o), 1);
    #2;
    rst_ni = 1'b1;
    step();

    // Reset mid-accumulation: next block must start empty.
    send_term(100, 100, 0);
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    step();
    ta = '{3, 4, 0, 1};
    tb = '{2, 2, 9, 1};
    run_block("after_rst", 0, 0);

    for (int blk = 0; blk < 25; blk++) begin
      for (int i = 0; i < NTerms; i++) begin
        ta[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 127))
                                            : int'($urandom_range(0, 127));
        tb[i] = int'($urandom_range(0, 127));
      end
      run_block("rand", 2, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
